cfu_requant: RTL and testbench

Output-side post-processing stage for the CFU convolution datapath. Consumes 32-bit int32 accumulators from the SIMD MAC stage, one element at a time. For each element it adds the per-channel bias, applies the TFLite per-tensor quantized multiplier and shift, adds the output offset and clamps to the activation range. The resulting int8 values are packed four per 32-bit word and returned to the CPU through a ready/valid response port.

---
 rtl/cfu_requant_pkg.sv | 25 ++
 rtl/cfu_srdhm_round.sv | 73 +++++++
 rtl/cfu_requant.sv | 149 ++++++++++++++
 tb/tb_cfu_requant.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cfu_requant_pkg.sv
// Shared constants and stage payload type for the CFU requantisation stage.
package cfu_requant_pkg;

    localparam logic [2:0] CFG_SEL_MULT    = 3'd0;
    localparam logic [2:0] CFG_SEL_SHIFT   = 3'd1;
    localparam logic [2:0] CFG_SEL_OFFSET  = 3'd2;
    localparam logic [2:0] CFG_SEL_ACT_MIN = 3'd3;
    localparam logic [2:0] CFG_SEL_ACT_MAX = 3'd4;

    localparam logic [31:0] CFG_MULT_RST    = 32'h4000_0000;
    localparam logic [5:0]  CFG_SHIFT_RST   = 6'd0;
    localparam logic [15:0] CFG_OFFSET_RST  = 16'd0;
    localparam logic [7:0]  CFG_ACT_MIN_RST = 8'h80;
    localparam logic [7:0]  CFG_ACT_MAX_RST = 8'h7F;

    localparam logic signed [31:0] INT32_MIN = 32'sh8000_0000;
    localparam logic signed [31:0] INT32_MAX = 32'sh7FFF_FFFF;

    typedef struct packed {
        logic signed [31:0] value;
        logic               last;
        logic               valid;
    } stage_t;

endpackage

// File: rtl/cfu_srdhm_round.sv
// Stages S2-S3: saturating rounding doubling high multiply followed by a
// round-half-away-from-zero divide by 2^rs. Both stages hold on stall.
module cfu_srdhm_round
    import cfu_requant_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  stage_t             in_stage,
    input  logic signed [31:0] mult,
    input  logic [5:0]         rs,
    output stage_t             out_stage,
    output logic               busy
);
    localparam logic signed [63:0] NUDGE_POS = 64'sd1073741824;
    localparam logic signed [63:0] NUDGE_NEG = 64'sd1 - 64'sd1073741824;
    localparam logic signed [63:0] TRUNC_BIAS = 64'sd2147483647;

    logic signed [31:0] xl;
    logic signed [63:0] prod_q;
    logic               sat_q;
    logic               last_q;
    logic               valid_q;

    logic signed [63:0] sum;
    logic signed [63:0] sum_adj;
    logic signed [31:0] h;
    logic signed [31:0] hs;
    logic [63:0]        mask;
    logic [63:0]        rem;
    logic [63:0]        thr;
    logic signed [31:0] q;

    assign xl   = in_stage.value;
    assign busy = valid_q | out_stage.valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            prod_q  <= '0;
            sat_q   <= 1'b0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else if (!stall) begin
            prod_q  <= {{32{xl[31]}}, xl} * {{32{mult[31]}}, mult};
            sat_q   <= (xl == INT32_MIN) && (mult == INT32_MIN);
            last_q  <= in_stage.last;
            valid_q <= in_stage.valid;
        end
    end

    // Negative sums get biased before the arithmetic shift so the divide truncates toward zero.
    always_comb begin
        sum     = prod_q + (prod_q[63] ? NUDGE_NEG : NUDGE_POS);
        sum_adj = sum[63] ? (sum + TRUNC_BIAS) : sum;
        h       = sat_q ? INT32_MAX : 32'(sum_adj >>> 31);
        hs      = h >>> rs;
        mask    = (64'd1 << rs) - 64'd1;
        rem     = {32'd0, h} & mask;
        thr     = (mask >> 1) + {63'd0, h[31]};
        q       = hs + {31'd0, (rem > thr)};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_stage <= '0;
        end else if (!stall) begin
            out_stage.value <= q;
            out_stage.last  <= last_q;
            out_stage.valid <= valid_q;
        end
    end

endmodule

// File: rtl/cfu_requant.sv
// Requantisation stage: bias add, quantised multiply/shift, offset, clamp,
// then packs int8 results four per word behind a ready/valid response port.
module cfu_requant
    import cfu_requant_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [2:0]  cfg_sel,
    input  logic [31:0] cfg_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_acc,
    input  logic [31:0] in_bias,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [2:0]  out_bytes,
    output logic        busy
);
    logic signed [31:0] mult;
    logic signed [5:0]  shift;
    logic signed [15:0] out_offset;
    logic signed [7:0]  act_min;
    logic signed [7:0]  act_max;

    logic        stall;
    logic [31:0] acc_q;
    logic [31:0] bias_q;
    logic        in_last_q;
    logic        in_valid_q;
    stage_t      s1;
    stage_t      s3;
    logic        core_busy;
    logic [1:0]  cnt;
    logic [31:0] lanes;

    logic [31:0]        x;
    logic [31:0]        xl;
    logic [4:0]         ls;
    logic [5:0]         rs;
    logic signed [31:0] y;
    logic signed [31:0] lo;
    logic signed [31:0] hi;
    logic [7:0]         lane_byte;
    logic [31:0]        merged;
    logic               complete;

    assign stall     = out_valid & ~out_ready;
    assign in_ready  = ~stall;
    assign busy      = in_valid_q | s1.valid | core_busy | (cnt != 2'd0) | out_valid;
    assign cfg_ready = ~busy;

    // Config only changes while idle, so in-flight elements never see a mix of settings.
    always_ff @(posedge clk) begin
        if (reset) begin
            mult       <= CFG_MULT_RST;
            shift      <= CFG_SHIFT_RST;
            out_offset <= CFG_OFFSET_RST;
            act_min    <= CFG_ACT_MIN_RST;
            act_max    <= CFG_ACT_MAX_RST;
        end else if (cfg_valid && cfg_ready) begin
            case (cfg_sel)
                CFG_SEL_MULT:    mult       <= cfg_data;
                CFG_SEL_SHIFT:   shift      <= cfg_data[5:0];
                CFG_SEL_OFFSET:  out_offset <= cfg_data[15:0];
                CFG_SEL_ACT_MIN: act_min    <= cfg_data[7:0];
                CFG_SEL_ACT_MAX: act_max    <= cfg_data[7:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        ls = shift[5] ? 5'd0 : shift[4:0];
        rs = shift[5] ? (6'd0 - shift) : 6'd0;
        x  = acc_q + bias_q;
        xl = x << ls;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q      <= '0;
            bias_q     <= '0;
            in_last_q  <= 1'b0;
            in_valid_q <= 1'b0;
            s1         <= '0;
        end else if (!stall) begin
            acc_q      <= in_acc;
            bias_q     <= in_bias;
            in_last_q  <= in_last;
            in_valid_q <= in_valid;
            s1.value   <= xl;
            s1.last    <= in_last_q;
            s1.valid   <= in_valid_q;
        end
    end

    cfu_srdhm_round u_srdhm (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .in_stage  (s1),
        .mult      (mult),
        .rs        (rs),
        .out_stage (s3),
        .busy      (core_busy)
    );

    always_comb begin
        y  = s3.value + {{16{out_offset[15]}}, out_offset};
        lo = {{24{act_min[7]}}, act_min};
        hi = {{24{act_max[7]}}, act_max};
        if (y < lo) begin
            lane_byte = act_min;
        end else if (y > hi) begin
            lane_byte = act_max;
        end else begin
            lane_byte = y[7:0];
        end
        merged   = lanes | ({24'd0, lane_byte} << {cnt, 3'b000});
        complete = s3.valid & (s3.last | (cnt == 2'd3));
    end

    // A word being consumed this cycle may be replaced by a new one completed by S4.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= 2'd0;
            lanes     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_bytes <= 3'd0;
        end else if (!stall) begin
            out_valid <= complete;
            if (complete) begin
                out_data  <= merged;
                out_bytes <= {1'b0, cnt} + 3'd1;
                cnt       <= 2'd0;
                lanes     <= '0;
            end else if (s3.valid) begin
                lanes <= merged;
                cnt   <= cnt + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_cfu_requant.sv
// Scoreboard bench for cfu_requant: a behavioural model predicts packed words,
// a monitor compares them as the DUT hands them over.
module tb_cfu_requant;
    localparam logic [2:0] SEL_MULT = 3'd0;
    localparam logic [2:0] SEL_SHIFT = 3'd1;
    localparam logic [2:0] SEL_OFF = 3'd2;
    localparam logic [2:0] SEL_MIN = 3'd3;
    localparam logic [2:0] SEL_MAX = 3'd4;
    localparam int I32_MIN = 32'h8000_0000;
    localparam int I32_MAX = 32'h7FFF_FFFF;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [2:0]  cfg_sel;
    logic [31:0] cfg_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_acc;
    logic [31:0] in_bias;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [2:0]  out_bytes;
    logic        busy;

    typedef struct {
        logic [31:0] data;
        logic [2:0]  bytes;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    int          m_mult, m_shift, m_off, m_min, m_max;
    int          m_cnt;
    logic [31:0] m_lanes;
    bit          done;
    bit          saw_low;
    int          lat;

    always #5 clk = ~clk;

    cfu_requant dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_sel   (cfg_sel),
        .cfg_data  (cfg_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_acc    (in_acc),
        .in_bias   (in_bias),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_bytes (out_bytes),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mult  = 32'h4000_0000;
        m_shift = 0;
        m_off   = 0;
        m_min   = -128;
        m_max   = 127;
        m_cnt   = 0;
        m_lanes = '0;
        exp_q.delete();
    endtask

    // Straight arithmetic statement of the requantisation rules.
    function automatic logic [7:0] ref_byte(input int acc, input int bias);
        int     x, xl, h, q, y, ls, rs;
        longint p, a, r;
        x  = acc + bias;
        ls = (m_shift > 0) ? m_shift : 0;
        rs = (m_shift < 0) ? -m_shift : 0;
        xl = x << ls;
        if (xl == I32_MIN && m_mult == I32_MIN) begin
            h = I32_MAX;
        end else begin
            p = longint'(xl) * longint'(m_mult);
            p = p + ((p >= 0) ? 64'sd1073741824 : (64'sd1 - 64'sd1073741824));
            h = int'(p / 64'sd2147483648);
        end
        a = (h < 0) ? -longint'(h) : longint'(h);
        r = (rs == 0) ? a : ((a + (64'sd1 <<< (rs - 1))) >>> rs);
        q = int'((h < 0) ? -r : r);
        y = q + m_off;
        if (y < m_min) y = m_min;
        else if (y > m_max) y = m_max;
        return y[7:0];
    endfunction

    task automatic model_accept(input logic [31:0] acc, input logic [31:0] bias, input logic last);
        logic [7:0] b;
        b = ref_byte(acc, bias);
        m_lanes = m_lanes | ({24'd0, b} << (8 * m_cnt));
        m_cnt++;
        if (last || m_cnt == 4) begin
            exp_q.push_back('{data: m_lanes, bytes: 3'(m_cnt)});
            m_lanes = '0;
            m_cnt   = 0;
        end
    endtask

    task automatic send(input logic [31:0] acc, input logic [31:0] bias, input logic last);
        bit ok;
        ok = 0;
        in_valid = 1'b1;
        in_acc   = acc;
        in_bias  = bias;
        in_last  = last;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (ok) begin
            model_accept(acc, bias, last);
        end else begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stayed 0 for 300 cycles, expected 1");
        end
    endtask

    task automatic cfg_write(input logic [2:0] sel, input logic [31:0] data, input bit expect_acc);
        cfg_valid = 1'b1;
        cfg_sel   = sel;
        cfg_data  = data;
        @(negedge clk);
        check("cfg_ready", {31'd0, cfg_ready}, {31'd0, expect_acc});
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        if (expect_acc) begin
            case (sel)
                SEL_MULT:  m_mult  = data;
                SEL_SHIFT: m_shift = int'($signed(data[5:0]));
                SEL_OFF:   m_off   = int'($signed(data[15:0]));
                SEL_MIN:   m_min   = int'($signed(data[7:0]));
                SEL_MAX:   m_max   = int'($signed(data[7:0]));
                default: ;
            endcase
        end
    endtask

    task automatic wait_drain();
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < 3000) begin
            @(posedge clk);
            #1;
            i++;
        end
        if (i >= 3000) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d words pending, expected 0", exp_q.size());
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic identity_cfg();
        cfg_write(SEL_MULT, 32'h4000_0000, 1);
        cfg_write(SEL_SHIFT, 32'd1, 1);
        cfg_write(SEL_OFF, 32'd0, 1);
        cfg_write(SEL_MIN, 32'hFFFF_FF80, 1);
        cfg_write(SEL_MAX, 32'd127, 1);
    endtask

    // Monitor: pops expectations on each handshake and checks hold-while-stalled.
    initial begin
        bit          prev_stall;
        logic [31:0] prev_data;
        logic [2:0]  prev_bytes;
        exp_t        w;
        prev_stall = 0;
        prev_data  = '0;
        prev_bytes = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_stall = 0;
            end else begin
                if (prev_stall) begin
                    check("hold_valid", {31'd0, out_valid}, 32'd1);
                    check("hold_data", out_data, prev_data);
                    check("hold_bytes", {29'd0, out_bytes}, {29'd0, prev_bytes});
                end
                if (out_valid && !out_ready) begin
                    check("stall_in_ready", {31'd0, in_ready}, 32'd0);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_word: got 0x%08h bytes %0d, expected no word", out_data, out_bytes);
                    end else begin
                        w = exp_q.pop_front();
                        check("word_data", out_data, w.data);
                        check("word_bytes", {29'd0, out_bytes}, {29'd0, w.bytes});
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
                prev_bytes = out_bytes;
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          off, lo, hi;
        logic [31:0] r_acc, r_bias;
        reset     = 1'b1;
        cfg_valid = 1'b0;
        cfg_sel   = '0;
        cfg_data  = '0;
        in_valid  = 1'b0;
        in_acc    = '0;
        in_bias   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_bytes", {29'd0, out_bytes}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Identity: four elements, latency from the fourth accept.
        identity_cfg();
        send(32'd1, 32'd0, 0);
        send(32'd2, 32'd0, 0);
        send(32'd3, 32'd0, 0);
        send(32'd4, 32'd0, 0);
        lat = 0;
        for (int i = 1; i <= 8 && lat == 0; i++) begin
            @(negedge clk);
            if (out_valid) lat = i;
        end
        check("latency", lat, 32'd5);
        @(posedge clk);
        #1;
        wait_drain();

        // Rounding and clamp.
        cfg_write(SEL_SHIFT, 32'hFFFF_FFFE, 1);
        cfg_write(SEL_OFF, 32'd10, 1);
        send(-32'sd300, 32'd0, 1);
        wait_drain();
        cfg_write(SEL_OFF, 32'hFFFF_FF80, 1);
        send(-32'sd300, 32'd0, 1);
        wait_drain();

        // Saturation corner of the doubling multiply.
        cfg_write(SEL_MULT, 32'h8000_0000, 1);
        cfg_write(SEL_SHIFT, 32'd0, 1);
        cfg_write(SEL_OFF, 32'd0, 1);
        send(32'h8000_0000, 32'd0, 1);
        wait_drain();

        // Partial word with bias, then a full word restarting at lane 0.
        identity_cfg();
        send(32'd5, 32'd5, 0);
        send(32'd7, 32'd0, 1);
        send(32'd9, 32'd0, 0);
        send(32'd1, 32'd0, 0);
        send(32'd2, 32'd0, 0);
        send(32'd3, 32'd0, 0);
        wait_drain();

        // Backpressure: three words, output held off for a while.
        out_ready = 1'b0;
        saw_low   = 0;
        fork
            begin
                for (int k = 0; k < 12; k++) send(32'(10 + k), 32'd0, 0);
            end
            begin
                repeat (30) begin
                    @(negedge clk);
                    if (!in_ready) saw_low = 1;
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        check("bp_in_ready_dropped", {31'd0, saw_low}, 32'd1);
        wait_drain();

        // Config write while busy is dropped.
        send(32'd3, 32'd0, 0);
        cfg_write(SEL_OFF, 32'd50, 0);
        send(32'd4, 32'd0, 1);
        wait_drain();

        // Randomised configurations with random backpressure.
        for (int c = 0; c < 6; c++) begin
            cfg_write(SEL_MULT, $urandom(), 1);
            if ($urandom_range(0, 1) == 1) cfg_write(SEL_SHIFT, $urandom_range(0, 63), 1);
            else cfg_write(SEL_SHIFT, 32'($urandom_range(0, 12)) - 32'd6, 1);
            off = int'($urandom_range(0, 400)) - 200;
            cfg_write(SEL_OFF, off, 1);
            lo = int'($urandom_range(0, 255));
            hi = int'($urandom_range(lo, 255));
            cfg_write(SEL_MIN, lo - 128, 1);
            cfg_write(SEL_MAX, hi - 128, 1);
            done = 0;
            fork
                begin
                    for (int k = 0; k < 40; k++) begin
                        r_acc  = ($urandom_range(0, 1) == 1) ? $urandom() : (32'($urandom_range(0, 2000)) - 32'd1000);
                        r_bias = ($urandom_range(0, 1) == 1) ? (32'($urandom_range(0, 200)) - 32'd100) : 32'd0;
                        if ($urandom_range(0, 7) == 0) begin
                            @(posedge clk);
                            #1;
                        end
                        send(r_acc, r_bias, (k == 39) || ($urandom_range(0, 4) == 0));
                    end
                    done = 1;
                end
                begin
                    while (!done) begin
                        @(posedge clk);
                        #1;
                        out_ready = ($urandom_range(0, 3) != 0);
                    end
                    out_ready = 1'b1;
                end
            join
            out_ready = 1'b1;
            wait_drain();
        end

        // Reset mid-stream drops partial lanes and restores defaults.
        cfg_write(SEL_MULT, 32'h2000_0000, 1);
        cfg_write(SEL_SHIFT, 32'd0, 1);
        cfg_write(SEL_OFF, 32'd0, 1);
        send(32'd100, 32'd0, 0);
        send(32'd50, 32'd0, 0);
        repeat (8) @(posedge clk);
        #1;
        @(negedge clk);
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_out_data", out_data, 32'd0);
        check("mid_rst_out_bytes", {29'd0, out_bytes}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        send(32'd100, 32'd0, 1);
        wait_drain();

        check("final_queue_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
